// File: rtl/sha3_miner_csr_pkg.sv
// miner_csr_pkg: register map, FSM encoding and bit positions for the mining CSR block.
// No ports; imported by the interface, sequencer and top.
package miner_csr_pkg;
    localparam logic [4:0] A_DIFF = 5'h08;
    localparam logic [4:0] A_NLO  = 5'h10;
    localparam logic [4:0] A_NHI  = 5'h11;
    localparam logic [4:0] A_CFG  = 5'h12;
    localparam logic [4:0] A_CMD  = 5'h13;
    localparam logic [4:0] A_STAT = 5'h14;
    localparam logic [4:0] A_SLO  = 5'h15;
    localparam logic [4:0] A_SHI  = 5'h16;
    localparam logic [4:0] A_IRQ  = 5'h17;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

    localparam int CMD_START  = 0;
    localparam int CMD_STOP   = 1;
    localparam int CMD_HALT   = 2;
    localparam int CFG_PADL   = 0;
    localparam int CFG_PADF   = 8;
    localparam int CFG_TEST   = 16;
    localparam int STAT_MS    = 0;
    localparam int STAT_STATE = 8;
    localparam int STAT_ERR   = 10;
    localparam int STAT_PEND  = 11;
    localparam int IRQ_PEND   = 0;
    localparam int IRQ_EN     = 1;
    localparam int CTL_RUN    = 0;
    localparam int CTL_TEST   = 1;
    localparam int CTL_HALT   = 2;
    localparam int CTL_PADL   = 3;
    localparam int CTL_PADF   = 11;
endpackage

// File: rtl/sha3_miner_csr_if.sv
// sha3_miner_csr_if: Avalon-MM slave bus from the HPS lightweight bridge.
// address/write/writedata/read driven by the master; readdata returned by the slave (latency 1).
interface sha3_miner_csr_if;
    logic [4:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    modport master (output address, write, writedata, read, input readdata);
    modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/sha3_miner_csr_seq.sv
// miner_csr_seq: job sequencer -- IDLE/FLUSH/RUN/DONE FSM, flush counter, miner_irq edge detect.
// In: start_i/stop_i/halt_i command strobes, miner_irq_i level from the engine.
// Out: state_o, run_o, halt_o for the control word; capture_o (latch solution, set pending);
//      start_acc_o (a START was accepted, clears job_err).
module miner_csr_seq
    import miner_csr_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start_i,
    input  logic   stop_i,
    input  logic   halt_i,
    input  logic   miner_irq_i,
    output state_t state_o,
    output logic   run_o,
    output logic   halt_o,
    output logic   capture_o,
    output logic   start_acc_o
);
    localparam int CW = $clog2(FLUSH_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          halt_q, halt_d, irq_prev_q, rise;

    assign rise    = miner_irq_i & ~irq_prev_q;
    assign state_o = state_q;
    assign run_o   = (state_q == S_RUN) || (state_q == S_DONE);
    assign halt_o  = halt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        capture_o   = 1'b0;
        start_acc_o = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) begin
                state_d     = S_FLUSH;
                cnt_d       = CW'(FLUSH_CYCLES - 1);
                halt_d      = 1'b0;
                start_acc_o = 1'b1;
            end
            S_FLUSH: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? S_RUN : S_FLUSH;
            end
            S_RUN: begin
                halt_d = halt_q | halt_i;
                // Halt stays asserted through DONE so the engine holds its result.
                if (rise) begin
                    state_d   = S_DONE;
                    halt_d    = 1'b1;
                    capture_o = 1'b1;
                end
            end
            default: ;
        endcase
        // STOP overrides everything, including a simultaneous START or completion.
        if (stop_i) begin
            state_d     = S_IDLE;
            halt_d      = 1'b0;
            capture_o   = 1'b0;
            start_acc_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            halt_q     <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_q     <= halt_d;
            irq_prev_q <= miner_irq_i;
        end
    end
endmodule

// File: rtl/sha3_miner_csr.sv
// sha3_miner_csr: host CSR front end for the SHA3-256 miner (register file, read mux, IRQ).
// avs: Avalon-MM slave bus. header/difficulty/start_nonce/control: job to the engine.
// miner_solution/miner_status/miner_irq: engine results. irq: pending & irq_en to the GIC.
module sha3_miner_csr
    import miner_csr_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sha3_miner_csr_if.slave        avs,
    output logic [255:0]           header,
    output logic [255:0]           difficulty,
    output logic [63:0]            start_nonce,
    output logic [18:0]            control,
    input  logic [63:0]            miner_solution,
    input  logic [6:0]             miner_status,
    input  logic                   miner_irq,
    output logic                   irq
);
    logic [255:0] hdr_q, diff_q;
    logic [63:0]  nonce_q, sol_q;
    logic [16:0]  cfg_q;
    logic [31:0]  rdata_q, rdata_d;
    logic         job_err_q, pending_q, irq_en_q, irq_q;
    logic         run, halt, capture, start_acc, busy, cfg_wr, cmd_wr, irq_wr;
    state_t       state;

    assign busy   = (state == S_FLUSH) || (state == S_RUN);
    assign cfg_wr = avs.write && (avs.address <= A_CFG);
    assign cmd_wr = avs.write && (avs.address == A_CMD);
    assign irq_wr = avs.write && (avs.address == A_IRQ);

    miner_csr_seq #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (cmd_wr && avs.writedata[CMD_START]),
        .stop_i      (cmd_wr && avs.writedata[CMD_STOP]),
        .halt_i      (cmd_wr && avs.writedata[CMD_HALT]),
        .miner_irq_i (miner_irq),
        .state_o     (state),
        .run_o       (run),
        .halt_o      (halt),
        .capture_o   (capture),
        .start_acc_o (start_acc)
    );

    always_comb begin
        control                = '0;
        control[CTL_PADF +: 8] = cfg_q[CFG_PADF +: 8];
        control[CTL_PADL +: 8] = cfg_q[CFG_PADL +: 8];
        control[CTL_HALT]      = halt;
        control[CTL_TEST]      = cfg_q[CFG_TEST];
        control[CTL_RUN]       = run;
    end

    always_comb begin
        rdata_d = '0;
        if (avs.address < A_DIFF)
            rdata_d = hdr_q[{avs.address[2:0], 5'd0} +: 32];
        else if (avs.address < A_NLO)
            rdata_d = diff_q[{avs.address[2:0], 5'd0} +: 32];
        else
            case (avs.address)
                A_NLO:   rdata_d = nonce_q[31:0];
                A_NHI:   rdata_d = nonce_q[63:32];
                A_CFG:   rdata_d = {15'd0, cfg_q};
                A_STAT: begin
                    rdata_d[STAT_MS +: 7]    = miner_status;
                    rdata_d[STAT_STATE +: 2] = state;
                    rdata_d[STAT_ERR]        = job_err_q;
                    rdata_d[STAT_PEND]       = pending_q;
                end
                A_SLO:   rdata_d = sol_q[31:0];
                A_SHI:   rdata_d = sol_q[63:32];
                A_IRQ: begin
                    rdata_d[IRQ_PEND] = pending_q;
                    rdata_d[IRQ_EN]   = irq_en_q;
                end
                default: rdata_d = '0;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_q     <= '0;
            diff_q    <= '0;
            nonce_q   <= '0;
            cfg_q     <= '0;
            sol_q     <= '0;
            job_err_q <= 1'b0;
            pending_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // Job parameters are frozen while the engine is flushing or running.
            if (cfg_wr && !busy) begin
                if (avs.address < A_DIFF)
                    hdr_q[{avs.address[2:0], 5'd0} +: 32] <= avs.writedata;
                else if (avs.address < A_NLO)
                    diff_q[{avs.address[2:0], 5'd0} +: 32] <= avs.writedata;
                else if (avs.address == A_NLO)
                    nonce_q[31:0] <= avs.writedata;
                else if (avs.address == A_NHI)
                    nonce_q[63:32] <= avs.writedata;
                else
                    cfg_q <= avs.writedata[16:0];
            end
            job_err_q <= start_acc ? 1'b0 : (job_err_q | (cfg_wr && busy));
            if (capture)
                sol_q <= miner_solution;
            // A capture in the same cycle as a W1C leaves pending set.
            pending_q <= capture | (pending_q & ~(irq_wr & avs.writedata[IRQ_PEND]));
            if (irq_wr)
                irq_en_q <= avs.writedata[IRQ_EN];
            irq_q <= pending_q & irq_en_q;
            if (avs.read)
                rdata_q <= rdata_d;
        end
    end

    assign header       = hdr_q;
    assign difficulty   = diff_q;
    assign start_nonce  = nonce_q;
    assign irq          = irq_q;
    assign avs.readdata = rdata_q;
endmodule
